// File: rtl/ps2_move_decoder_pkg.sv
// ps2_move_decoder_pkg
//   Shared definitions for the PS/2 movement decoder: scan-code constants
//   (set 2), parser state encoding, direction bit indices and small decode
//   helpers used by ps2_move_decoder.
//   Optional build macro PS2_MOVE_WASD_EN (consumed by ps2_move_decoder)
//   enables the WASD aliases declared here.
package ps2_move_decoder_pkg;

  // Prefix bytes
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;

  // Arrow keys (only meaningful after an E0 prefix)
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // WASD aliases (non-extended)
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;

  // Bit positions in the held vector. Opposing directions differ only in
  // bit 0 of the index, which the decoder exploits (opposite = idx ^ 1).
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } dir_hit_t;

  // Keyboard/controller status bytes (BAT ok, ack, echo, resend, errors,
  // pause prefix). They never belong to a movement sequence.
  function automatic logic is_abort_byte(input logic [7:0] code);
    case (code)
      8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'hE1: is_abort_byte = 1'b1;
      default:                                         is_abort_byte = 1'b0;
    endcase
  endfunction

  function automatic dir_hit_t arrow_decode(input logic [7:0] code);
    dir_hit_t r;
    r = '0;
    case (code)
      SC_UP:    begin r.hit = 1'b1; r.idx = DIR_UP;    end
      SC_DOWN:  begin r.hit = 1'b1; r.idx = DIR_DOWN;  end
      SC_LEFT:  begin r.hit = 1'b1; r.idx = DIR_LEFT;  end
      SC_RIGHT: begin r.hit = 1'b1; r.idx = DIR_RIGHT; end
      default:  r = '0;
    endcase
    return r;
  endfunction

  function automatic dir_hit_t wasd_decode(input logic [7:0] code);
    dir_hit_t r;
    r = '0;
    case (code)
      SC_W:    begin r.hit = 1'b1; r.idx = DIR_UP;    end
      SC_S:    begin r.hit = 1'b1; r.idx = DIR_DOWN;  end
      SC_A:    begin r.hit = 1'b1; r.idx = DIR_LEFT;  end
      SC_D:    begin r.hit = 1'b1; r.idx = DIR_RIGHT; end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_move_decoder_idle_timer.sv
// ps2_idle_timer
//   Counts cycles since the last received byte and saturates at
//   TIMEOUT_CYCLES. expire is a one-cycle pulse on the cycle whose clock edge
//   moves the counter onto the limit; a clear on that same cycle suppresses it
//   so a late byte is never lost to the timeout.
//   Ports:
//     clock   in  system clock
//     resetn  in  asynchronous active-low reset
//     clear   in  restart the idle count (a byte was received)
//     expire  out one-cycle timeout pulse
module ps2_idle_timer #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] count;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + TW'(1);
    end
  end

  assign expire = !clear && (count == (LIMIT - TW'(1)));

endmodule

// File: rtl/ps2_move_decoder.sv
// ps2_move_decoder
//   Turns the PS/2 scan-code set 2 byte stream into held-direction levels
//   for the sprite logic plus a step strobe per direction make code
//   (typematic repeats included). Make/break is tracked per key so a
//   direction stays asserted while the key is held; opposing directions held
//   together cancel, orthogonal ones combine. After TIMEOUT_CYCLES without a
//   byte the held keys and parser are cleared to recover from lost breaks.
//   Build macro: PS2_MOVE_WASD_EN adds W/S/A/D (1D/1B/1C/23, non-extended)
//   as aliases of up/down/left/right.
//   Ports:
//     clock, resetn          clock, asynchronous active-low reset
//     key_data, key_valid    received byte and its one-cycle strobe
//     move_up/down/left/right registered direction levels
//     step                   one-cycle pulse per direction make
//     last_code              last decoded direction code (make or break)
module ps2_move_decoder
  import ps2_move_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] key_data,
  input  logic       key_valid,
  output logic       move_up,
  output logic       move_down,
  output logic       move_left,
  output logic       move_right,
  output logic       step,
  output logic [7:0] last_code
);

  logic       expire;
  state_t     state, state_next;
  logic [3:0] held, held_next;
  logic [3:0] move_vec;
  logic       make_hit, break_hit;
  logic [1:0] dir_idx;
  dir_hit_t   arrow, wasd;

  ps2_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clock  (clock),
    .resetn (resetn),
    .clear  (key_valid),
    .expire (expire)
  );

  always_comb begin
    state_next = state;
    make_hit   = 1'b0;
    break_hit  = 1'b0;
    dir_idx    = '0;
    arrow      = arrow_decode(key_data);
`ifdef PS2_MOVE_WASD_EN
    wasd       = wasd_decode(key_data);
`else
    wasd       = '0;
`endif

    if (key_valid) begin
      state_next = ST_IDLE;
      if (!is_abort_byte(key_data)) begin
        case (state)
          ST_IDLE: begin
            if (key_data == SC_EXT) begin
              state_next = ST_EXT;
            end else if (key_data == SC_BRK) begin
              state_next = ST_BRK;
            end else if (wasd.hit) begin
              make_hit = 1'b1;
              dir_idx  = wasd.idx;
            end
          end
          ST_EXT: begin
            if (key_data == SC_BRK) begin
              state_next = ST_EXT_BRK;
            end else if (arrow.hit) begin
              make_hit = 1'b1;
              dir_idx  = arrow.idx;
            end
          end
          ST_BRK: begin
            if (wasd.hit) begin
              break_hit = 1'b1;
              dir_idx   = wasd.idx;
            end
          end
          ST_EXT_BRK: begin
            if (arrow.hit) begin
              break_hit = 1'b1;
              dir_idx   = arrow.idx;
            end
          end
          default: state_next = ST_IDLE;
        endcase
      end
    end else if (expire) begin
      state_next = ST_IDLE;
    end

    held_next = held;
    if (expire) begin
      held_next = '0;
    end else if (make_hit) begin
      held_next[dir_idx] = 1'b1;
    end else if (break_hit) begin
      held_next[dir_idx] = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      held      <= '0;
      step      <= 1'b0;
      last_code <= '0;
    end else begin
      state <= state_next;
      held  <= held_next;
      step  <= make_hit;
      if (make_hit || break_hit) begin
        last_code <= key_data;
      end
    end
  end

  // Each direction is driven only when its opposite (index ^ 1) is released.
  // Registered from held, so move_* trail held by one cycle.
  for (genvar gi = 0; gi < 4; gi++) begin : g_move
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        move_vec[gi] <= 1'b0;
      end else begin
        move_vec[gi] <= held[gi] & ~held[gi ^ 1];
      end
    end
  end

  assign move_up    = move_vec[DIR_UP];
  assign move_down  = move_vec[DIR_DOWN];
  assign move_left  = move_vec[DIR_LEFT];
  assign move_right = move_vec[DIR_RIGHT];

endmodule

// File: tb/tb_ps2_move_decoder.sv
// tb_ps2_move_decoder
//   Table-driven directed vectors, hand-written timeout / reset sequences and
//   a randomized byte stream checked against a prefix-queue reference model.
module tb_ps2_move_decoder;

  localparam int TO = 100;
`ifdef PS2_MOVE_WASD_EN
  localparam bit WASD = 1'b1;
`else
  localparam bit WASD = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] key_data = 8'h00;
  logic       key_valid = 1'b0;
  logic       move_up, move_down, move_left, move_right, step;
  logic [7:0] last_code;

  int errors = 0;
  int checks = 0;
  int step_cnt = 0;

  ps2_move_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .key_data   (key_data),
    .key_valid  (key_valid),
    .move_up    (move_up),
    .move_down  (move_down),
    .move_left  (move_left),
    .move_right (move_right),
    .step       (step),
    .last_code  (last_code)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (step) step_cnt++;

  function automatic logic [3:0] moves();
    return {move_right, move_left, move_down, move_up};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Lands 1 time unit after a falling edge, well away from the active edge.
  task automatic cyc();
    @(negedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    key_data  = b;
    key_valid = 1'b1;
    cyc();
    key_valid = 1'b0;
  endtask

  // ---------------- reference model ----------------
  logic [7:0] pfx[$];
  logic [3:0] m_held;
  logic [7:0] m_last;
  int         m_idle;

  function automatic int arrow_of(input logic [7:0] b);
    case (b)
      8'h75: return 0;
      8'h72: return 1;
      8'h6B: return 2;
      8'h74: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int wasd_of(input logic [7:0] b);
    if (!WASD) return -1;
    case (b)
      8'h1D: return 0;
      8'h1B: return 1;
      8'h1C: return 2;
      8'h23: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [3:0] expect_moves(input logic [3:0] h);
    return {h[3] & ~h[2], h[2] & ~h[3], h[1] & ~h[0], h[0] & ~h[1]};
  endfunction

  // Returns 1 when the byte completes a make sequence.
  function automatic bit model_byte(input logic [7:0] b);
    int n, d;
    bit made;
    made = 1'b0;
    if (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'hE1}) begin
      pfx.delete();
      return 1'b0;
    end
    pfx.push_back(b);
    n = pfx.size();
    if ((n == 1 && (b == 8'hE0 || b == 8'hF0)) ||
        (n == 2 && pfx[0] == 8'hE0 && b == 8'hF0))
      return 1'b0;
    d = -1;
    if (n == 1 && wasd_of(b) >= 0) begin
      d = wasd_of(b); m_held[d] = 1'b1; made = 1'b1;
    end else if (n == 2 && pfx[0] == 8'hE0 && arrow_of(b) >= 0) begin
      d = arrow_of(b); m_held[d] = 1'b1; made = 1'b1;
    end else if (n == 2 && pfx[0] == 8'hF0 && wasd_of(b) >= 0) begin
      d = wasd_of(b); m_held[d] = 1'b0;
    end else if (n == 3 && pfx[0] == 8'hE0 && pfx[1] == 8'hF0 && arrow_of(b) >= 0) begin
      d = arrow_of(b); m_held[d] = 1'b0;
    end
    if (d >= 0) m_last = b;
    pfx.delete();
    return made;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    string      name;
    logic [7:0] b0, b1, b2;
    int         n;
    logic [3:0] exp_move;   // {right,left,down,up}
    int         exp_steps;
    logic [7:0] exp_last;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input string nm, input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input int n, input logic [3:0] mv,
                               input int st, input logic [7:0] lc);
    vec_t v;
    v.name = nm; v.b0 = b0; v.b1 = b1; v.b2 = b2; v.n = n;
    v.exp_move = mv; v.exp_steps = st; v.exp_last = lc;
    return v;
  endfunction

  initial begin
    vecs.push_back(mkv("up_make",     8'hE0, 8'h75, 8'h00, 2, 4'b0001, 1, 8'h75));
    vecs.push_back(mkv("up_break",    8'hE0, 8'hF0, 8'h75, 3, 4'b0000, 0, 8'h75));
    vecs.push_back(mkv("up_make2",    8'hE0, 8'h75, 8'h00, 2, 4'b0001, 1, 8'h75));
    vecs.push_back(mkv("down_oppose", 8'hE0, 8'h72, 8'h00, 2, 4'b0000, 1, 8'h72));
    vecs.push_back(mkv("down_break",  8'hE0, 8'hF0, 8'h72, 3, 4'b0001, 0, 8'h72));
    vecs.push_back(mkv("up_break2",   8'hE0, 8'hF0, 8'h75, 3, 4'b0000, 0, 8'h75));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mkv("left_typematic", 8'hE0, 8'h6B, 8'h00, 2, 4'b0100, 1, 8'h6B));
    vecs.push_back(mkv("left_break",  8'hE0, 8'hF0, 8'h6B, 3, 4'b0000, 0, 8'h6B));
    vecs.push_back(mkv("right_make",  8'hE0, 8'h74, 8'h00, 2, 4'b1000, 1, 8'h74));
    vecs.push_back(mkv("diag_up",     8'hE0, 8'h75, 8'h00, 2, 4'b1001, 1, 8'h75));
    vecs.push_back(mkv("lr_oppose",   8'hE0, 8'h6B, 8'h00, 2, 4'b0001, 1, 8'h6B));
    vecs.push_back(mkv("aa_byte",     8'hAA, 8'h00, 8'h00, 1, 4'b0001, 0, 8'h6B));
    vecs.push_back(mkv("fa_byte",     8'hFA, 8'h00, 8'h00, 1, 4'b0001, 0, 8'h6B));
    vecs.push_back(mkv("keypad_75",   8'h75, 8'h00, 8'h00, 1, 4'b0001, 0, 8'h6B));
    vecs.push_back(mkv("wasd_s",      8'h1B, 8'h00, 8'h00, 1,
                       WASD ? 4'b0000 : 4'b0001, WASD ? 1 : 0, WASD ? 8'h1B : 8'h6B));
    vecs.push_back(mkv("ext_abort",   8'hE0, 8'hAA, 8'h75, 3,
                       WASD ? 4'b0000 : 4'b0001, 0, WASD ? 8'h1B : 8'h6B));
    vecs.push_back(mkv("ext_ext",     8'hE0, 8'hE0, 8'h75, 3,
                       WASD ? 4'b0000 : 4'b0001, 0, WASD ? 8'h1B : 8'h6B));
    vecs.push_back(mkv("clr_up",      8'hE0, 8'hF0, 8'h75, 3,
                       WASD ? 4'b0010 : 4'b0000, 0, 8'h75));
    vecs.push_back(mkv("clr_left",    8'hE0, 8'hF0, 8'h6B, 3,
                       WASD ? 4'b1010 : 4'b1000, 0, 8'h6B));
    vecs.push_back(mkv("clr_right",   8'hE0, 8'hF0, 8'h74, 3,
                       WASD ? 4'b0010 : 4'b0000, 0, 8'h74));
    vecs.push_back(mkv("wasd_s_brk",  8'hF0, 8'h1B, 8'h00, 2, 4'b0000, 0,
                       WASD ? 8'h1B : 8'h74));
  end

  // ---------------- main sequence ----------------
  logic [7:0] pool [14] = '{8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74,
                            8'h1D, 8'h1B, 8'h1C, 8'h23, 8'hAA, 8'hE1};

  initial begin
    logic [3:0] prev_held;
    logic [7:0] b;
    bit         exp_step, valid;
    int         burst;

    // Reset state
    cyc(); cyc();
    check("reset_moves", {28'h0, moves()}, 32'h0);
    check("reset_step", {31'h0, step}, 32'h0);
    check("reset_last", {24'h0, last_code}, 32'h0);
    resetn = 1'b1;
    cyc();

    // Directed table
    for (int i = 0; i < vecs.size(); i++) begin
      step_cnt = 0;
      send_byte(vecs[i].b0);
      if (vecs[i].n > 1) send_byte(vecs[i].b1);
      if (vecs[i].n > 2) send_byte(vecs[i].b2);
      cyc(); cyc();
      check({vecs[i].name, "_move"}, {28'h0, moves()}, {28'h0, vecs[i].exp_move});
      check({vecs[i].name, "_steps"}, step_cnt, vecs[i].exp_steps);
      check({vecs[i].name, "_last"}, {24'h0, last_code}, {24'h0, vecs[i].exp_last});
      $display("vector %0d %s move=%b steps=%0d last=%h", i, vecs[i].name, moves(), step_cnt, last_code);
    end

    // Timeout clears a stuck key: held cleared on the 100th idle edge, move one later
    send_byte(8'hE0);
    send_byte(8'h74);
    check("to_step", {31'h0, step}, 32'h1);
    for (int i = 0; i < TO; i++) cyc();
    check("to_still_held", {31'h0, move_right}, 32'h1);
    cyc();
    check("to_cleared", {31'h0, move_right}, 32'h0);
    $display("timeout sequence move_right=%b", move_right);

    // Lone E0 expires, so the following 74 is a keypad code
    send_byte(8'hE0);
    for (int i = 0; i < TO; i++) cyc();
    send_byte(8'h74);
    check("to_prefix_step", {31'h0, step}, 32'h0);
    cyc(); cyc();
    check("to_prefix_move", {31'h0, move_right}, 32'h0);
    $display("expired prefix then 74 move_right=%b", move_right);

    // Byte on the limit cycle wins and is processed from EXT
    send_byte(8'hE0);
    for (int i = 0; i < TO - 1; i++) cyc();
    send_byte(8'h74);
    check("limit_byte_step", {31'h0, step}, 32'h1);
    cyc(); cyc();
    check("limit_byte_move", {31'h0, move_right}, 32'h1);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
    cyc(); cyc();
    check("limit_byte_brk", {31'h0, move_right}, 32'h0);
    $display("limit-cycle byte sequence done");

    // Reset between E0 and F0 of a break
    send_byte(8'hE0); send_byte(8'h75);
    cyc(); cyc();
    check("rst_pre_up", {31'h0, move_up}, 32'h1);
    send_byte(8'hE0);
    resetn = 1'b0;
    #1;
    check("rst_async_moves", {28'h0, moves()}, 32'h0);
    check("rst_async_last", {24'h0, last_code}, 32'h0);
    cyc();
    resetn = 1'b1;
    cyc();
    send_byte(8'h75);
    check("rst_75_step", {31'h0, step}, 32'h0);
    cyc(); cyc();
    check("rst_75_move", {28'h0, moves()}, 32'h0);
    $display("reset mid-sequence moves=%b last=%h", moves(), last_code);

    // Randomized stream against the model
    resetn = 1'b0;
    cyc();
    check("rnd_reset", {28'h0, moves()}, 32'h0);
    pfx.delete();
    m_held = '0; m_last = '0; m_idle = 0; burst = 0;
    resetn = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (burst > 0) begin
        burst--;
        valid = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        burst = $urandom_range(TO - 2, TO + 20);
        valid = 1'b0;
      end else begin
        valid = ($urandom_range(0, 2) != 0);
      end
      b = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 13)];
      prev_held = m_held;
      exp_step = 1'b0;
      if (valid) begin
        m_idle = 0;
        exp_step = model_byte(b);
      end else if (m_idle < TO) begin
        m_idle++;
        if (m_idle == TO) begin
          m_held = '0;
          pfx.delete();
        end
      end
      key_data  = b;
      key_valid = valid;
      cyc();
      key_valid = 1'b0;
      check("rnd_cycle", {19'h0, moves(), step, last_code},
            {19'h0, expect_moves(prev_held), exp_step, m_last});
      if (valid)
        $display("rnd %0d byte=%h move=%b step=%b last=%h", c, b, moves(), step, last_code);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
